// File: rtl/pipe_ctrl_pkg.sv
// ============================================================
// Package : pipe_ctrl_pkg
// Brief   : Opcodes, control-bundle layout and bubble for the 5-stage pipeline control unit.
// Revision: 1.0
// ============================================================
`default_nettype none

package pipe_ctrl_pkg;

  localparam int C_WB_W = 2;
  localparam int C_M_W  = 3;
  localparam int C_EX_W = 4;

  localparam int C_WB_REGWRITE = 0;
  localparam int C_WB_MEMTOREG = 1;
  localparam int C_M_BRANCH    = 0;
  localparam int C_M_MEMREAD   = 1;
  localparam int C_M_MEMWRITE  = 2;
  localparam int C_EX_REGDST   = 0;
  localparam int C_EX_ALUSRC   = 3;

  localparam logic [5:0] C_OP_RTYPE = 6'd0;
  localparam logic [5:0] C_OP_J     = 6'd2;
  localparam logic [5:0] C_OP_BEQ   = 6'd4;
  localparam logic [5:0] C_OP_BNE   = 6'd5;
  localparam logic [5:0] C_OP_ADDI  = 6'd8;
  localparam logic [5:0] C_OP_LW    = 6'd35;
  localparam logic [5:0] C_OP_SW    = 6'd43;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_BNE   = 2'b11
  } aluop_e;

  typedef struct packed {
    logic [C_WB_W-1:0] wb;
    logic [C_M_W-1:0]  m;
    logic [C_EX_W-1:0] ex;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t C_BUBBLE = '0;

  function automatic logic [C_EX_W-1:0] ex_bits(input logic alusrc, input aluop_e aluop,
                                                input logic regdst);
    return {alusrc, aluop, regdst};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_unit_if.sv
// ============================================================
// Interface : pipe_ctrl_unit_if
// Brief     : Datapath <-> pipeline control unit signal bundle.
// Revision  : 1.0
// ============================================================
`default_nettype none

interface pipe_ctrl_unit_if #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  logic [XLEN-1:0]  id_inst;
  logic             mem_ready;
  logic             br_taken;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             jump;
  logic [3:0]       ex_ctrl;
  logic [2:0]       mem_ctrl;
  logic [1:0]       wb_ctrl;
  logic [RA_W-1:0]  ex_dst;
  logic [RA_W-1:0]  mem_dst;
  logic [RA_W-1:0]  wb_dst;
  logic             illegal;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_inst, mem_ready, br_taken,
    input  pc_write, ifid_write, ifid_flush, jump, ex_ctrl, mem_ctrl, wb_ctrl,
           ex_dst, mem_dst, wb_dst, illegal, stall_cnt
  );

  modport slave (
    input  id_inst, mem_ready, br_taken,
    output pc_write, ifid_write, ifid_flush, jump, ex_ctrl, mem_ctrl, wb_ctrl,
           ex_dst, mem_dst, wb_dst, illegal, stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
// ============================================================
// Module  : ctrl_decode
// Brief   : Combinational opcode decoder producing control bundles and source usage.
// Revision: 1.0
// ============================================================
`default_nettype none

module ctrl_decode #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [XLEN-1:0]             inst,
  output pipe_ctrl_pkg::ctrl_bundle_t bundle,
  output logic [RA_W-1:0]             dst,
  output logic                        uses_rs,
  output logic                        uses_rt,
  output logic                        jump,
  output logic                        illegal
);
  import pipe_ctrl_pkg::*;

  logic [5:0]      w_op;
  logic [RA_W-1:0] w_rt;
  logic [RA_W-1:0] w_rd;

  assign w_op = inst[XLEN-1 -: 6];
  assign w_rt = inst[16 +: RA_W];
  assign w_rd = inst[11 +: RA_W];

  always_comb begin
    bundle  = C_BUBBLE;
    dst     = '0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    jump    = 1'b0;
    illegal = 1'b0;
    // The all-zero word is the NOP, even though its opcode field reads as R-type.
    if (inst != '0) begin
      case (w_op)
        C_OP_RTYPE: begin
          bundle.wb[C_WB_REGWRITE] = 1'b1;
          bundle.ex = ex_bits(1'b0, ALUOP_FUNCT, 1'b1);
          dst       = w_rd;
          uses_rs   = 1'b1;
          uses_rt   = 1'b1;
        end
        C_OP_LW: begin
          bundle.wb[C_WB_REGWRITE] = 1'b1;
          bundle.wb[C_WB_MEMTOREG] = 1'b1;
          bundle.m[C_M_MEMREAD]    = 1'b1;
          bundle.ex = ex_bits(1'b1, ALUOP_ADD, 1'b0);
          dst       = w_rt;
          uses_rs   = 1'b1;
        end
        C_OP_SW: begin
          bundle.m[C_M_MEMWRITE] = 1'b1;
          bundle.ex = ex_bits(1'b1, ALUOP_ADD, 1'b0);
          uses_rs   = 1'b1;
          uses_rt   = 1'b1;
        end
        C_OP_BEQ, C_OP_BNE: begin
          bundle.m[C_M_BRANCH] = 1'b1;
          bundle.ex = ex_bits(1'b0, (w_op == C_OP_BNE) ? ALUOP_BNE : ALUOP_SUB, 1'b0);
          uses_rs   = 1'b1;
          uses_rt   = 1'b1;
        end
        C_OP_ADDI: begin
          bundle.wb[C_WB_REGWRITE] = 1'b1;
          bundle.ex = ex_bits(1'b1, ALUOP_ADD, 1'b0);
          dst       = w_rt;
          uses_rs   = 1'b1;
        end
        C_OP_J:  jump    = 1'b1;
        default: illegal = 1'b1;
      endcase
    end
    if (dst == '0) bundle.wb[C_WB_REGWRITE] = 1'b0;
  end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
// ============================================================
// Module  : pipe_ctrl_unit
// Brief   : Pipelined control unit: decode, ID/EX-EX/MEM-MEM/WB control registers, hazard stall, flush, freeze.
// Revision: 1.0
// ============================================================
`default_nettype none

module pipe_ctrl_unit #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_ctrl_unit_if.slave   bus
);
  import pipe_ctrl_pkg::*;

  ctrl_bundle_t      w_dec;
  logic [RA_W-1:0]   w_dec_dst;
  logic              w_uses_rs;
  logic              w_uses_rt;
  logic              w_dec_jump;
  logic              w_dec_illegal;

  ctrl_bundle_t      r_idex;
  logic [RA_W-1:0]   r_idex_dst;
  logic [C_WB_W-1:0] r_exmem_wb;
  logic [C_M_W-1:0]  r_exmem_m;
  logic [RA_W-1:0]   r_exmem_dst;
  logic [C_WB_W-1:0] r_memwb_wb;
  logic [RA_W-1:0]   r_memwb_dst;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [RA_W-1:0]   w_rs;
  logic [RA_W-1:0]   w_rt;
  logic              w_rs_live;
  logic              w_rt_live;
  logic              w_ex_hit;
  logic              w_mem_hit;
  logic              w_load_use;
  logic              w_raw;
  logic              w_haz;

  ctrl_decode #(
    .XLEN (XLEN),
    .RA_W (RA_W)
  ) u_ctrl_decode (
    .inst    (bus.id_inst),
    .bundle  (w_dec),
    .dst     (w_dec_dst),
    .uses_rs (w_uses_rs),
    .uses_rt (w_uses_rt),
    .jump    (w_dec_jump),
    .illegal (w_dec_illegal)
  );

  assign w_rs      = bus.id_inst[21 +: RA_W];
  assign w_rt      = bus.id_inst[16 +: RA_W];
  assign w_rs_live = w_uses_rs && (w_rs != '0);
  assign w_rt_live = w_uses_rt && (w_rt != '0);

  assign w_ex_hit  = (w_rs_live && (r_idex_dst == w_rs)) || (w_rt_live && (r_idex_dst == w_rt));
  assign w_mem_hit = (w_rs_live && (r_exmem_dst == w_rs)) || (w_rt_live && (r_exmem_dst == w_rt));

  assign w_load_use = r_idex.m[C_M_MEMREAD] && w_ex_hit;

  generate
    if (FWD_EN) begin : g_fwd
      assign w_raw = 1'b0;
    end else begin : g_no_fwd
      assign w_raw = (r_idex.wb[C_WB_REGWRITE] && w_ex_hit) ||
                     (r_exmem_wb[C_WB_REGWRITE] && w_mem_hit);
    end
  endgenerate

  assign w_haz = w_load_use || w_raw;

  // A taken branch outranks the hazard: the stalled instruction is squashed anyway.
  assign bus.pc_write   = bus.mem_ready && (bus.br_taken || !w_haz);
  assign bus.ifid_write = bus.mem_ready && (bus.br_taken || !w_haz);
  assign bus.ifid_flush = bus.mem_ready && (bus.br_taken || (!w_haz && w_dec_jump));
  assign bus.jump       = bus.mem_ready && !bus.br_taken && !w_haz && w_dec_jump;
  // Held off while frozen so a frozen illegal word still produces a single pulse.
  assign bus.illegal    = bus.mem_ready && !w_haz && w_dec_illegal;

  assign bus.ex_ctrl   = r_idex.ex;
  assign bus.ex_dst    = r_idex_dst;
  assign bus.mem_ctrl  = r_exmem_m;
  assign bus.mem_dst   = r_exmem_dst;
  assign bus.wb_ctrl   = r_memwb_wb;
  assign bus.wb_dst    = r_memwb_dst;
  assign bus.stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idex      <= C_BUBBLE;
      r_idex_dst  <= '0;
      r_exmem_wb  <= '0;
      r_exmem_m   <= '0;
      r_exmem_dst <= '0;
      r_memwb_wb  <= '0;
      r_memwb_dst <= '0;
      r_stall_cnt <= '0;
    end else if (bus.mem_ready) begin
      r_memwb_wb  <= r_exmem_wb;
      r_memwb_dst <= r_exmem_dst;
      if (bus.br_taken) begin
        r_idex      <= C_BUBBLE;
        r_idex_dst  <= '0;
        r_exmem_wb  <= '0;
        r_exmem_m   <= '0;
        r_exmem_dst <= '0;
      end else begin
        r_exmem_wb  <= r_idex.wb;
        r_exmem_m   <= r_idex.m;
        r_exmem_dst <= r_idex_dst;
        if (w_haz) begin
          r_idex     <= C_BUBBLE;
          r_idex_dst <= '0;
          if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end else begin
          r_idex     <= w_dec;
          r_idex_dst <= w_dec_dst;
        end
      end
    end
  end

endmodule

`default_nettype wire
